// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared RV32I memory-access constants, FSM state enum and sizing helpers
package rv_mem_pkg;
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    // Shift the addressed byte/half down to bit 0, then sign- or zero-extend it.
    function automatic logic [31:0] ld_extend(input logic [31:0] word, input logic [1:0] off,
                                              input logic [2:0] funct3);
        logic [31:0] w_s;
        w_s = word >> {off, 3'b000};
        return funct3 == F3_B  ? {{24{w_s[7]}}, w_s[7:0]} :
               funct3 == F3_H  ? {{16{w_s[15]}}, w_s[15:0]} :
               funct3 == F3_BU ? {24'd0, w_s[7:0]} :
               funct3 == F3_HU ? {16'd0, w_s[15:0]} : w_s;
    endfunction

    // Byte-lane enables for a store of the given size at byte offset off.
    function automatic logic [3:0] st_byteen(input logic [1:0] off, input logic [2:0] funct3);
        return (funct3 == F3_B || funct3 == F3_BU) ? 4'b0001 << off :
               (funct3 == F3_H || funct3 == F3_HU) ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction
endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: DEPTH x 32-bit synchronous RAM with byte enables; read-during-write returns new data
module dmem_bank #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;
    logic [31:0] w_merged;

    // Merge enabled write lanes over the stored word; this is both the new contents and the read value.
    always_comb begin
        w_merged = r_mem[i_addr];
        for (int i = 0; i < 4; i++)
            w_merged[8*i +: 8] = i_be[i] ? i_wdata[8*i +: 8] : r_mem[i_addr][8*i +: 8];
    end

    // Access port: write back merged word and register it as read data.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[i_addr] <= w_merged;
            r_rdata       <= w_merged;
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage load/store responder with wait states, RV32I sizing and error flagging
module dmem_responder
    import rv_mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT0 = LATENCY == 0 ? 4'd0 : 4'(LATENCY - 1);

    state_t        r_state, w_next;
    logic [3:0]    r_cnt;
    logic          r_write, r_err;
    logic [2:0]    r_f3;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;

    logic          w_take, w_req_err, w_acc, w_acc_wr;
    logic [2:0]    w_acc_f3;
    logic [AW+1:0] w_acc_addr;
    logic [31:0]   w_acc_wdata, w_lane_wdata, w_bank_rdata;
    logic          w_unused_addr;

    assign w_take        = r_state == IDLE && req_valid;
    assign w_unused_addr = |req_addr[31:AW+2];
    assign w_req_err     = req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11 ||
                           (req_write && req_funct3[2]) ||
                           ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) ||
                           (req_funct3 == F3_W && req_addr[1:0] != 2'b00);

    // With zero wait states the access happens on the accept edge, so it uses the live request.
    assign w_acc_wr    = r_state == IDLE ? req_write : r_write;
    assign w_acc_f3    = r_state == IDLE ? req_funct3 : r_f3;
    assign w_acc_addr  = r_state == IDLE ? req_addr[AW+1:0] : r_addr;
    assign w_acc_wdata = r_state == IDLE ? req_wdata : r_wdata;
    assign w_acc       = !clr && ((w_take && !w_req_err && LATENCY == 0) ||
                                  (r_state == BUSY && r_cnt == 4'd0));
    assign w_lane_wdata = w_acc_f3 == F3_B ? {4{w_acc_wdata[7:0]}} :
                          w_acc_f3 == F3_H ? {2{w_acc_wdata[15:0]}} : w_acc_wdata;

    dmem_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank (
        .clk     (clk),
        .i_en    (w_acc),
        .i_be    (w_acc_wr ? st_byteen(w_acc_addr[1:0], w_acc_f3) : 4'b0000),
        .i_addr  (w_acc_addr[AW+1:2]),
        .i_wdata (w_lane_wdata),
        .o_rdata (w_bank_rdata)
    );

    // Next-state: accept in IDLE, count down in BUSY, hold RESP until consumed.
    always_comb begin
        w_next = r_state;
        if (w_take)
            w_next = (w_req_err || LATENCY == 0) ? RESP : BUSY;
        else if (r_state == BUSY && r_cnt == 4'd0)
            w_next = RESP;
        else if (r_state == RESP && rsp_ready)
            w_next = IDLE;
    end

    // State register plus request latch and wait counter; clr aborts any transaction.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_write <= req_write;
                r_f3    <= req_funct3;
                r_addr  <= req_addr[AW+1:0];
                r_wdata <= req_wdata;
                r_err   <= w_req_err;
                r_cnt   <= CNT0;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    assign req_ready = r_state == IDLE;
    assign rsp_valid = r_state == RESP;
    assign rsp_err   = rsp_valid && r_err;
    assign rsp_rdata = (rsp_valid && !r_write && !r_err) ? ld_extend(w_bank_rdata, r_addr[1:0], r_f3) : 32'd0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed table, corner sequences and random traffic against a byte-level model
module tb_dmem_responder;
    import rv_mem_pkg::*;

    typedef struct {
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        bit          err;
    } vec_t;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_ready = 1'b1;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic        rsp_err   [2];
    logic [31:0] rsp_rdata [2];

    int checks = 0;
    int errors = 0;
    logic [7:0] mb [int];

    always #5 clk = ~clk;

    // Instance 1 has one wait state, instance 0 has none; index equals latency.
    dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut1 (
        .clk(clk), .clr(clr), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    dmem_responder #(.DEPTH(1024), .LATENCY(0)) u_dut0 (
        .clk(clk), .clr(clr), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Reference: little-endian byte memory of 4096 bytes per instance.
    function automatic void model(input int s, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output bit er);
        int sz, b;
        logic [31:0] v;
        er = f3 == 3 || f3 >= 6 || (wr && f3 >= 4) || ((f3 == 1 || f3 == 5) && a % 2 != 0) ||
             (f3 == 2 && a % 4 != 0);
        rd = 32'd0;
        if (er) return;
        sz = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : 4;
        b  = s * 4096 + int'(a % 4096);
        if (wr) begin
            for (int i = 0; i < sz; i++) mb[b + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[b + i];
            if (f3 < 4 && sz < 4 && v[8*sz - 1]) v = v | (32'hFFFF_FFFF << (8 * sz));
            rd = v;
        end
    endfunction

    function automatic vec_t vec(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd, input bit err);
        vec_t t;
        t.wr = wr; t.f3 = f3; t.addr = a; t.wdata = wd; t.rd = rd; t.err = err;
        return t;
    endfunction

    // One full request/response with rsp_ready high; checks latency and returns DUT and model results.
    task automatic xact(input int s, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output logic [31:0] e_rd, output bit e_er);
        int n;
        model(s, wr, f3, a, wd, e_rd, e_er);
        @(negedge clk);
        req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid[s] = 1'b1;
        @(posedge clk);
        #1 req_valid[s] = 1'b0;
        n = 0;
        while (rsp_valid[s] !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        chk($sformatf("latency s%0d a%h", s, a), 32'(n), e_er ? 32'd0 : 32'(s));
        rd = rsp_rdata[s];
        er = rsp_err[s];
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        tbl[$];
        logic [31:0] rd, e_rd, held;
        logic        er;
        bit          e_er;
        int          n;

        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("reset req_ready s%0d", s), 32'(req_ready[s]), 32'd1);
            chk($sformatf("reset rsp_valid s%0d", s), 32'(rsp_valid[s]), 32'd0);
            chk($sformatf("reset rsp_rdata s%0d", s), rsp_rdata[s], 32'd0);
            chk($sformatf("reset rsp_err s%0d", s), 32'(rsp_err[s]), 32'd0);
        end
        @(negedge clk) clr = 1'b0;

        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 16; w++) begin
                xact(s, 1'b1, F3_W, 32'(w * 4), $urandom(), rd, er, e_rd, e_er);
                chk("prefill err", 32'(er), 32'd0);
            end

        tbl.push_back(vec(1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 0));
        tbl.push_back(vec(0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 0));
        tbl.push_back(vec(1, F3_B, 32'h13, 32'h80, 32'h0, 0));
        tbl.push_back(vec(0, F3_W, 32'h10, 32'h0, 32'h80ADBEEF, 0));
        tbl.push_back(vec(0, F3_B, 32'h13, 32'h0, 32'hFFFFFF80, 0));
        tbl.push_back(vec(0, F3_BU, 32'h13, 32'h0, 32'h00000080, 0));
        tbl.push_back(vec(1, F3_H, 32'h12, 32'h1234, 32'h0, 0));
        tbl.push_back(vec(0, F3_HU, 32'h12, 32'h0, 32'h00001234, 0));
        tbl.push_back(vec(0, F3_W, 32'h11, 32'h0, 32'h0, 1));
        tbl.push_back(vec(0, F3_W, 32'h10, 32'h0, 32'h1234BEEF, 0));
        tbl.push_back(vec(1, F3_H, 32'h13, 32'hFFFF, 32'h0, 1));
        tbl.push_back(vec(0, 3'd3, 32'h10, 32'h0, 32'h0, 1));
        tbl.push_back(vec(1, F3_BU, 32'h10, 32'h11, 32'h0, 1));
        tbl.push_back(vec(1, F3_W, 32'h10, 32'h0, 32'h0, 0));
        tbl.push_back(vec(1, F3_W, 32'h10, 32'h1234BEEF, 32'h0, 0));
        tbl.push_back(vec(0, F3_W, 32'h10, 32'h0, 32'h1234BEEF, 0));
        tbl.push_back(vec(1, F3_H, 32'h12, 32'h8001, 32'h0, 0));
        tbl.push_back(vec(0, F3_H, 32'h12, 32'h0, 32'hFFFF8001, 0));
        tbl.push_back(vec(0, F3_B, 32'h10, 32'h0, 32'hFFFFFFEF, 0));
        tbl.push_back(vec(0, F3_HU, 32'h10, 32'h0, 32'h0000BEEF, 0));
        tbl.push_back(vec(0, F3_W, 32'h10, 32'h0, 32'h8001BEEF, 0));
        foreach (tbl[i]) begin
            xact(1, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, er, e_rd, e_er);
            chk($sformatf("tbl[%0d] rdata", i), rd, tbl[i].rd);
            chk($sformatf("tbl[%0d] err", i), 32'(er), 32'(tbl[i].err));
        end

        // Back-pressure: response held for five cycles; a request offered meanwhile is ignored.
        rsp_ready = 1'b0;
        @(negedge clk);
        req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h10; req_valid[1] = 1'b1;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        n = 0;
        while (rsp_valid[1] !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        chk("bp latency", 32'(n), 32'd1);
        @(negedge clk);
        req_write = 1'b1; req_wdata = 32'h0; req_valid[1] = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp rsp_valid", 32'(rsp_valid[1]), 32'd1);
            chk("bp rdata", rsp_rdata[1], 32'h8001BEEF);
            chk("bp req_ready", 32'(req_ready[1]), 32'd0);
        end
        @(negedge clk);
        req_valid[1] = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("bp release req_ready", 32'(req_ready[1]), 32'd1);
        xact(1, 1'b0, F3_W, 32'h10, 32'h0, rd, er, e_rd, e_er);
        chk("bp ignored store", rd, 32'h8001BEEF);

        // Abort: clr in BUSY must drop the store and its response.
        @(negedge clk);
        req_write = 1'b1; req_funct3 = F3_W; req_addr = 32'h20; req_wdata = 32'h55; req_valid[1] = 1'b1;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        chk("abort in busy", 32'(req_ready[1]), 32'd0);
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk("abort rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("abort req_ready", 32'(req_ready[1]), 32'd1);
        @(negedge clk) clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("abort no late rsp", 32'(rsp_valid[1]), 32'd0);
        xact(1, 1'b0, F3_W, 32'h20, 32'h0, rd, er, e_rd, e_er);
        chk("abort prior value", rd, e_rd);

        // Wrap on the zero-latency instance.
        xact(0, 1'b1, F3_W, 32'h1000, 32'hA5A5A5A5, rd, er, e_rd, e_er);
        chk("wrap store err", 32'(er), 32'd0);
        xact(0, 1'b0, F3_W, 32'h0, 32'h0, rd, er, e_rd, e_er);
        chk("wrap load", rd, 32'hA5A5A5A5);

        for (int k = 0; k < 300; k++) begin
            int          s;
            logic [31:0] a;
            s = int'($urandom_range(0, 1));
            a = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            xact(s, 1'($urandom()), 3'($urandom()), a, $urandom(), rd, er, e_rd, e_er);
            chk($sformatf("rnd%0d rdata", k), rd, e_rd);
            chk($sformatf("rnd%0d err", k), 32'(er), 32'(e_er));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
